// File: rtl/bank_sequencer.sv
// Tile sequencer: loads ARR_SIZE*ROWS producer words round-robin into a banked
// buffer, then issues ROWS stream beats to the array and pulses done.
module bank_sequencer #(
  parameter int ARR_SIZE = 4,
  parameter int ROWS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        stream_en,
  output logic [15:0] buf_data,
  output logic [7:0]  buf_addr,
  output logic [1:0]  buf_state,
  output logic        busy,
  output logic        done
);

  localparam int BANK_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(ARR_SIZE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_STREAM = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   beat_q, beat_d;
  logic [1:0]         op_q, op_d;
  logic [7:0]         addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      beat_q  <= '0;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Buffer op registers default to NOP every cycle; address/data only move
  // when a store or stream beat is actually issued.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    beat_d  = beat_q;
    op_d    = OP_NOP;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      bank_d  = '0;
      row_d   = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            bank_d  = '0;
            row_d   = '0;
            beat_d  = '0;
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            op_d   = OP_STORE;
            addr_d = 8'(bank_q);
            data_d = in_data;
            if (bank_q == BANK_LAST) begin
              bank_d = '0;
              // Last word of the tile: leave LOAD so in_ready drops at once.
              if (row_q == ROW_LAST) begin
                row_d   = '0;
                beat_d  = '0;
                state_d = S_STREAM;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              bank_d = bank_q + 1'b1;
            end
          end
        end

        S_STREAM: begin
          if (stream_en) begin
            op_d   = OP_STREAM;
            addr_d = '0;
            if (beat_q == ROW_LAST) begin
              beat_d  = '0;
              state_d = S_DONE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end

        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          bank_d  = '0;
          row_d   = '0;
          beat_d  = '0;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake and activity flags follow the state directly.
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign done      = done_q;
  assign buf_state = op_q;
  assign buf_addr  = addr_q;
  assign buf_data  = data_q;

endmodule

// File: tb/tb_bank_sequencer.sv
// Self-checking bench for bank_sequencer: directed vector table, hand-written
// corner sequences, and random traffic against a word/beat-counting model.
module tb_bank_sequencer;

  localparam int ARR  = 4;
  localparam int RW   = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_STREAM = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        stream_en = 1'b0;
  logic        in_ready;
  logic [15:0] buf_data;
  logic [7:0]  buf_addr;
  logic [1:0]  buf_state;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  bank_sequencer #(.ARR_SIZE(ARR), .ROWS(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stream_en(stream_en), .buf_data(buf_data), .buf_addr(buf_addr),
    .buf_state(buf_state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: tracks tile progress as a word count and a beat count.
  int          m_mode  = M_IDLE;
  int          m_words = 0;
  int          m_beats = 0;
  logic [1:0]  e_state = 2'b00;
  logic [7:0]  e_addr  = 8'h0;
  logic [15:0] e_data  = 16'h0;
  logic        e_done  = 1'b0;

  task automatic model_step();
    if (!rst) begin
      m_mode = M_IDLE; m_words = 0; m_beats = 0;
      e_state = 2'b00; e_addr = 8'h0; e_data = 16'h0; e_done = 1'b0;
      return;
    end
    e_state = 2'b00;
    e_done  = 1'b0;
    if (abort) begin
      m_mode = M_IDLE; m_words = 0; m_beats = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_LOAD; m_words = 0; end
      M_LOAD: if (in_valid) begin
        e_state = 2'b01;
        e_addr  = 8'(m_words % ARR);
        e_data  = in_data;
        m_words++;
        if (m_words == ARR * RW) begin m_mode = M_STREAM; m_beats = 0; end
      end
      M_STREAM: if (stream_en) begin
        e_state = 2'b10;
        e_addr  = 8'h0;
        m_beats++;
        if (m_beats == RW) m_mode = M_DONE;
      end
      default: begin e_done = 1'b1; m_mode = M_IDLE; end
    endcase
  endtask

  function automatic logic [28:0] dut_vec();
    return {in_ready, busy, done, buf_state, buf_addr, buf_data};
  endfunction

  function automatic logic [28:0] model_vec();
    return {(m_mode == M_LOAD), (m_mode == M_LOAD || m_mode == M_STREAM),
            e_done, e_state, e_addr, e_data};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic st, input logic ab,
                        input logic iv, input logic [15:0] d, input logic se);
    rst = r; start = st; abort = ab; in_valid = iv; in_data = d; stream_en = se;
  endtask

  // One clock: edge, model update, sample on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  typedef struct {
    logic        rst_n, st, ab, iv, se;
    logic [15:0] din;
    logic        x_ready, x_busy, x_done;
    logic [1:0]  x_state;
    logic [7:0]  x_addr;
    logic [15:0] x_data;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic st, input logic ab,
                              input logic iv, input logic [15:0] d, input logic se,
                              input logic xr, input logic xb, input logic xd,
                              input logic [1:0] xs, input logic [7:0] xa,
                              input logic [15:0] xdat);
    vec_t v;
    v.rst_n = r; v.st = st; v.ab = ab; v.iv = iv; v.din = d; v.se = se;
    v.x_ready = xr; v.x_busy = xb; v.x_done = xd;
    v.x_state = xs; v.x_addr = xa; v.x_data = xdat;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    // Reset, start, 8 loads with data 1..8, then stream 1,0,0,1 and done.
    tbl[0] = mk(0,0,0,0,16'h0,0, 0,0,0, 2'b00, 8'h0, 16'h0);
    tbl[1] = mk(1,1,0,0,16'h0,0, 1,1,0, 2'b00, 8'h0, 16'h0);
    for (int k = 1; k <= 8; k++)
      tbl[k+1] = mk(1,0,0,1,16'(k),0, (k < 8),1,0, 2'b01, 8'((k-1) % ARR), 16'(k));
    tbl[10] = mk(1,0,0,0,16'h0,1, 0,1,0, 2'b10, 8'h0, 16'h8);
    tbl[11] = mk(1,0,0,0,16'h0,0, 0,1,0, 2'b00, 8'h0, 16'h8);
    tbl[12] = mk(1,0,0,0,16'h0,0, 0,1,0, 2'b00, 8'h0, 16'h8);
    tbl[13] = mk(1,0,0,0,16'h0,1, 0,0,0, 2'b10, 8'h0, 16'h8);
    tbl[14] = mk(1,0,0,0,16'h0,0, 0,0,1, 2'b00, 8'h0, 16'h8);
    tbl[15] = mk(1,0,0,0,16'h0,0, 0,0,0, 2'b00, 8'h0, 16'h8);

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].rst_n, tbl[i].st, tbl[i].ab, tbl[i].iv, tbl[i].din, tbl[i].se);
      cycle();
      chk($sformatf("vec%0d", i), 32'(dut_vec()),
          32'({tbl[i].x_ready, tbl[i].x_busy, tbl[i].x_done,
               tbl[i].x_state, tbl[i].x_addr, tbl[i].x_data}));
      $display("vec %0d: state=%b addr=%0d data=%h done=%b busy=%b ready=%b",
               i, buf_state, buf_addr, buf_data, done, busy, in_ready);
    end

    // in_valid every other cycle: stores only after accepts, banks unbroken.
    set_in(1,1,0,0,16'h0,0); cycle();
    for (int k = 0; k < 16; k++) begin
      set_in(1,0,0,(k % 2 == 0),16'(16'h100 + k),0);
      cycle();
      if (k % 2 == 0) begin
        chk("toggle_store", 32'(buf_state), 32'd1);
        chk("toggle_bank", 32'(buf_addr), 32'((k / 2) % ARR));
      end else begin
        chk("toggle_nop", 32'(buf_state), 32'd0);
      end
    end
    chk("toggle_in_stream", 32'({in_ready, busy}), 32'b01);
    set_in(1,0,0,0,16'h0,1); cycle(); cycle();
    set_in(1,0,0,0,16'h0,0); cycle();
    chk("toggle_done", 32'(done), 32'd1);
    cycle();
    $display("seq toggle-load finished");

    // Abort after three accepted words, with start and a word in the same cycle.
    set_in(1,1,0,0,16'h0,0); cycle();
    for (int k = 0; k < 3; k++) begin set_in(1,0,0,1,16'(16'h200 + k),0); cycle(); end
    set_in(1,1,1,1,16'h2FF,0); cycle();
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_state", 32'(buf_state), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    set_in(1,0,0,1,16'h0,0);
    for (int k = 0; k < 3; k++) begin cycle(); chk("abort_no_done", 32'(done), 32'd0); end
    set_in(1,1,0,0,16'h0,0); cycle();
    set_in(1,0,0,1,16'hAAAA,0); cycle();
    chk("abort_restart_bank", 32'(buf_addr), 32'd0);
    chk("abort_restart_data", 32'(buf_data), 32'hAAAA);
    set_in(1,0,1,0,16'h0,0); cycle();
    $display("seq abort finished");

    // start together with abort in IDLE stays idle.
    set_in(1,1,1,0,16'h0,0); cycle();
    chk("start_abort_idle", 32'({busy, in_ready}), 32'd0);

    // Load with start held high (ignored), one beat, then reset mid-stream.
    set_in(1,1,0,0,16'h0,0); cycle();
    for (int k = 0; k < ARR * RW; k++) begin
      set_in(1,1,0,1,16'(16'h300 + k),0); cycle();
      chk("start_in_load_bank", 32'(buf_addr), 32'(k % ARR));
    end
    set_in(1,0,0,0,16'h0,1); cycle();
    chk("stream_beat", 32'(buf_state), 32'd2);
    set_in(0,0,0,0,16'h0,1); cycle();
    chk("reset_mid_stream", 32'(dut_vec()), 32'd0);
    set_in(1,1,0,0,16'h0,0); cycle();
    chk("first_start_after_reset", 32'({busy, in_ready}), 32'b11);
    set_in(1,0,0,0,16'h0,0);
    for (int k = 0; k < 4; k++) begin cycle(); chk("reset_no_done", 32'(done), 32'd0); end
    $display("seq reset finished");

    // Random traffic checked only by the model.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(149) != 0), ($urandom_range(7) == 0),
             ($urandom_range(39) == 0), $urandom_range(1) == 1,
             16'($urandom), $urandom_range(1) == 1);
      cycle();
    end
    $display("random phase finished");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_sequencer.md
BANK_SEQUENCER -- requirements
Module: bank_sequencer

Interface
REQ-001 SHALL have parameter ARR_SIZE, default 4, number of banks (2..16).
REQ-002 SHALL have parameter ROWS, default 8, words loaded per bank per tile (1..256).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a tile.
REQ-006 SHALL have port abort  input  1  returns the block to IDLE.
REQ-007 SHALL have port in_valid  input  1  producer word valid.
REQ-008 SHALL have port in_data  input  16  producer word.
REQ-009 SHALL have port in_ready  output  1  word accepted when in_valid && in_ready.
REQ-010 SHALL have port stream_en  input  1  downstream array can consume a stream beat.
REQ-011 SHALL have port buf_data  output  16  word to the banked buffer.
REQ-012 SHALL have port buf_addr  output  8  target bank index.
REQ-013 SHALL have port buf_state  output  2  buffer op: 00 NOP, 01 store, 10 stream; 11 never driven.
REQ-014 SHALL have port busy  output  1  high in LOAD or STREAM.
REQ-015 SHALL have port done  output  1  one-cycle pulse at tile completion.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, STREAM, DONE.
REQ-017 IDLE: start=1 -> LOAD next cycle; bank_cnt and row_cnt cleared to 0.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 in_ready SHALL be 1 only in LOAD; combinational from state, not from in_valid.
REQ-020 LOAD, on accept: register buf_state=01, buf_addr=bank_cnt, buf_data=in_data; visible the cycle after accept (1-cycle latency).
REQ-021 LOAD, no accept: buf_state=00, buf_addr and buf_data hold their previous values.
REQ-022 bank_cnt SHALL increment per accept and wrap ARR_SIZE-1 -> 0; row_cnt SHALL increment on each wrap.
REQ-023 Accept of word ARR_SIZE*ROWS-1 (bank_cnt=ARR_SIZE-1, row_cnt=ROWS-1) -> STREAM next cycle; in_ready drops that cycle; no extra word accepted.
REQ-024 STREAM: each cycle with stream_en=1 registers buf_state=10, buf_addr=0 and increments beat_cnt; stream_en=0 registers buf_state=00, beat_cnt holds.
REQ-025 After ROWS stream beats -> DONE; DONE lasts one cycle with done=1, buf_state=00, then IDLE.
REQ-026 busy SHALL be 1 in LOAD and STREAM, 0 in IDLE and DONE.
REQ-027 abort=1 in any state -> IDLE next cycle; buf_state=00, counters cleared, no done pulse; abort has priority over start and accept in the same cycle.
REQ-028 start and abort together in IDLE -> stay IDLE.
REQ-029 Counter widths SHALL be clog2-sized from parameters; buf_addr zero-extended to 8 bits.

Reset
REQ-030 While rst=0 at a rising edge: state=IDLE; counters=0; buf_state=00, buf_addr=0, buf_data=0, done=0, busy=0, in_ready=0.
REQ-031 Reset mid-LOAD or mid-STREAM SHALL discard the tile; no done pulse.
REQ-032 First start SHALL be honoured on the first edge after rst returns to 1.

Verification
REQ-033 ARR_SIZE=4, ROWS=2, in_valid=1 with data 0x0001..0x0008 -> buf_state=01 for 8 cycles, buf_addr 0,1,2,3,0,1,2,3, buf_data 0x0001..0x0008; then STREAM.
REQ-034 In LOAD, in_valid toggles every other cycle -> buf_state=01 only the cycle after each accept, else 00; bank sequence unbroken.
REQ-035 In STREAM (ROWS=2), stream_en=1,0,0,1 -> buf_state 10,00,00,10, then done=1 one cycle, then busy=0.
REQ-036 abort asserted after 3 accepted words -> IDLE next cycle, in_ready=0, buf_state=00, no done; next start loads from bank 0.
REQ-037 rst=0 during STREAM -> all outputs at reset values next cycle; start pulsed during LOAD -> no effect on counters.
